// File: rtl/alu_result_queue.sv
// Capture FIFO for ALU results with a show-ahead head entry.
// Also keeps a running sum of accepted results and a sticky wrap flag.
module alu_result_queue #(
    parameter int DATA_W = 6,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_result,
    input  logic [SEL_W-1:0]          in_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W+DATA_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]    count,
    input  logic                      clr_acc,
    output logic [ACC_W-1:0]          acc,
    output logic                      acc_ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = SEL_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum;
    logic             push, pop;

    // Ready depends only on the registered count, so a full queue never passes through.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign count   = count_q;
    assign acc     = acc_q;
    assign acc_ovf = acc_ovf_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        acc_base  = clr_acc ? '0 : acc_q;
        sum       = {1'b0, acc_base} + (ACC_W + 1)'(in_result);
        acc_d     = acc_base;
        acc_ovf_d = acc_ovf_q & ~clr_acc;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear is applied before the add, so a same-cycle push starts a fresh sum.
        if (push) begin
            acc_d     = sum[ACC_W-1:0];
            acc_ovf_d = acc_ovf_d | sum[ACC_W];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

    // NOTE: storage is not reset; count gates visibility, so stale contents never reach out_data.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_sel, in_result};
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: stimulus pushes expected entries into a
// scoreboard queue, a separate monitor pops and compares on every DUT pop.
module tb_alu_result_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_result;
    logic [1:0] in_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       clr_acc;
    logic [9:0] acc;
    logic       acc_ovf;

    int tests  = 0;
    int failed = 0;
    logic [7:0] sb [$];
    logic       ok;

    always #5 clk = ~clk;

    alu_result_queue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .clr_acc   (clr_acc),
        .acc       (acc),
        .acc_ovf   (acc_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; record an accepted push in the scoreboard before the edge.
    task automatic step(input logic v, input logic [1:0] s, input logic [5:0] r,
                        input logic ordy, input logic clr, output logic accepted);
        in_valid  = v;
        in_sel    = s;
        in_result = r;
        out_ready = ordy;
        clr_acc   = clr;
        @(negedge clk);
        accepted = v && in_ready && !rst;
        if (accepted) sb.push_back({s, r});
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the head against the scoreboard whenever a pop is about to occur.
    initial begin
        logic [7:0] exp_data;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL pop_unexpected: got %0h, required no entry", out_data);
                    end else begin
                        exp_data = sb.pop_front();
                        check("pop_data", 32'(out_data), 32'(exp_data));
                    end
                end else if (!out_valid) begin
                    check("empty_data", 32'(out_data), 32'(0));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_result = '0;
        out_ready = 1'b0; clr_acc = 1'b0;

        // 1. Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     32'(count),     32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_acc",       32'(acc),       32'(0));
        check("rst_acc_ovf",   32'(acc_ovf),   32'(0));
        rst = 1'b0;

        // 2. Three pushes, then drain in order
        step(1, 2'd2, 6'h0C, 0, 0, ok);
        step(1, 2'd3, 6'h31, 0, 0, ok);
        step(1, 2'd1, 6'h07, 0, 0, ok);
        check("t2_count", 32'(count),    32'(3));
        check("t2_head",  32'(out_data), 32'(8'h8C));
        check("t2_acc",   32'(acc),      32'(68));
        repeat (3) step(0, 2'd0, 6'h00, 1, 0, ok);
        check("t2_drained", 32'(count), 32'(0));

        // 3. Fill, block on full, pop one, then the held 5th entry goes in across the wrap
        step(1, 2'd0, 6'h01, 0, 0, ok);
        step(1, 2'd1, 6'h02, 0, 0, ok);
        step(1, 2'd2, 6'h03, 0, 0, ok);
        step(1, 2'd3, 6'h04, 0, 0, ok);
        check("t3_full_count", 32'(count),    32'(4));
        check("t3_in_ready",   32'(in_ready), 32'(0));
        step(1, 2'd0, 6'h05, 0, 0, ok);
        check("t3_blocked",    32'(ok),       32'(0));
        step(1, 2'd0, 6'h05, 1, 0, ok);
        check("t3_no_passthru", 32'(ok),      32'(0));
        check("t3_after_pop",  32'(count),    32'(3));
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) step(1, 2'd0, 6'h05, 0, 0, ok);
        check("t3_fifth_in",   32'(ok),       32'(1));
        check("t3_refill",     32'(count),    32'(4));
        repeat (4) step(0, 2'd0, 6'h00, 1, 0, ok);
        check("t3_drained",    32'(count),    32'(0));

        // 4. Steady push+pop keeps count at 2
        step(1, 2'd0, 6'h10, 0, 0, ok);
        step(1, 2'd1, 6'h11, 0, 0, ok);
        for (int i = 0; i < 6; i++) begin
            step(1, 2'd2, 6'(6'h20 + i), 1, 0, ok);
            check("t4_count", 32'(count), 32'(2));
        end
        repeat (2) step(0, 2'd0, 6'h00, 1, 0, ok);
        check("t4_drained", 32'(count), 32'(0));

        // 5. Accumulator wrap and clear-with-push
        step(0, 2'd0, 6'h00, 0, 1, ok);
        check("t5_clr_acc", 32'(acc),     32'(0));
        check("t5_clr_ovf", 32'(acc_ovf), 32'(0));
        repeat (16) step(1, 2'd3, 6'h3F, 1, 0, ok);
        check("t5_acc16",   32'(acc),     32'(1008));
        check("t5_ovf16",   32'(acc_ovf), 32'(0));
        step(1, 2'd3, 6'h3F, 1, 0, ok);
        check("t5_acc17",   32'(acc),     32'(47));
        check("t5_ovf17",   32'(acc_ovf), 32'(1));
        step(1, 2'd0, 6'h05, 1, 1, ok);
        check("t5_clr_push_acc", 32'(acc),     32'(5));
        check("t5_clr_push_ovf", 32'(acc_ovf), 32'(0));
        check("t5_fifo_kept",    32'(count),   32'(1));
        repeat (2) step(0, 2'd0, 6'h00, 1, 0, ok);
        check("t5_drained", 32'(count), 32'(0));

        // 6. Reset mid-operation discards entries and wins over a push
        step(1, 2'd1, 6'h01, 0, 0, ok);
        step(1, 2'd1, 6'h02, 0, 0, ok);
        step(1, 2'd1, 6'h03, 0, 0, ok);
        check("t6_count", 32'(count), 32'(3));
        rst = 1'b1;
        step(1, 2'd1, 6'h2A, 0, 0, ok);
        sb.delete();
        rst = 1'b0;
        check("t6_rst_count",     32'(count),     32'(0));
        check("t6_rst_out_valid", 32'(out_valid), 32'(0));
        check("t6_rst_out_data",  32'(out_data),  32'(0));
        check("t6_rst_in_ready",  32'(in_ready),  32'(1));
        check("t6_rst_acc",       32'(acc),       32'(0));
        check("t6_rst_ovf",       32'(acc_ovf),   32'(0));
        step(1, 2'd1, 6'h15, 0, 0, ok);
        check("t6_new_count", 32'(count),    32'(1));
        check("t6_new_head",  32'(out_data), 32'(8'h55));
        check("t6_new_acc",   32'(acc),      32'(21));
        step(0, 2'd0, 6'h00, 1, 0, ok);

        repeat (2) step(0, 2'd0, 6'h00, 0, 0, ok);
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
